// File: rtl/riscmakers_cache_data_bank.sv
// Multi-way byte-writable data store for the set-associative L1 caches: parallel read of all ways,
// one-hot way write mask, valid/ready handshake with backpressure and a zero-fill sweep after reset.
module riscmakers_cache_data_bank #(
  parameter int    NB_WAYS    = 4,
  parameter int    NB_COL     = 16,
  parameter int    COL_WIDTH  = 8,
  parameter int    RAM_DEPTH  = 256,
  parameter string WRITE_MODE = "WRITE_FIRST",
  parameter int    OUT_REG    = 1,
  localparam int   AW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int   LW         = NB_COL * COL_WIDTH
) (
  input  logic                  clka,
  input  logic                  rsta,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [NB_WAYS-1:0]    req_way_we,
  input  logic [NB_COL-1:0]     req_be,
  input  logic [LW-1:0]         req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NB_WAYS*LW-1:0] rsp_rdata
);

  localparam bit WF = (WRITE_MODE == "WRITE_FIRST");

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state, w_state_next;
  logic [AW-1:0]           r_cnt, w_cnt_next;
  logic                    r_init_done, w_init_done_next;
  logic                    r_v1;
  logic                    w_out_valid, w_advance, w_accept, w_init, w_ena;
  logic [AW-1:0]           w_addr;
  logic [NB_WAYS*LW-1:0]   w_dout;

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_init_done <= w_init_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_init_done_next = r_init_done;
    case (r_state)
      ST_INIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == AW'(RAM_DEPTH - 1)) begin
          w_state_next     = ST_RUN;
          w_cnt_next       = '0;
          w_init_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  assign init_done = r_init_done;
  assign w_init    = (r_state == ST_INIT);
  assign w_advance = !w_out_valid || rsp_ready;
  assign req_ready = (r_state == ST_RUN) && w_advance;
  assign w_accept  = req_valid && req_ready;
  // Gating with rsta keeps a request presented on the reset edge from touching the RAM.
  assign w_ena     = (w_accept || w_init) && !rsta;
  assign w_addr    = w_init ? r_cnt : req_addr;

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_v1 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= w_accept;
    end
  end

  genvar gi, gc;
  generate
    for (gi = 0; gi < NB_WAYS; gi++) begin : g_way
      for (gc = 0; gc < NB_COL; gc++) begin : g_col
        logic [COL_WIDTH-1:0] r_mem [RAM_DEPTH];
        logic [COL_WIDTH-1:0] r_dout;
        logic [COL_WIDTH-1:0] w_wbyte;
        logic                 w_we;

        assign w_we    = w_init || (w_accept && req_way_we[gi] && req_be[gc]);
        assign w_wbyte = w_init ? '0 : req_wdata[gc*COL_WIDTH +: COL_WIDTH];

        always_ff @(posedge clka) begin
          if (w_ena && w_we) begin
            r_mem[w_addr] <= w_wbyte;
          end
        end

        // Read port only moves on an accepted request, so a stalled response stays put.
        always_ff @(posedge clka) begin
          if (rsta) begin
            r_dout <= '0;
          end else if (w_accept) begin
            r_dout <= (WF && w_we) ? w_wbyte : r_mem[w_addr];
          end
        end

        assign w_dout[gi*LW + gc*COL_WIDTH +: COL_WIDTH] = r_dout;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic                  r_v2;
      logic [NB_WAYS*LW-1:0] r_out;

      always_ff @(posedge clka) begin
        if (rsta) begin
          r_v2  <= 1'b0;
          r_out <= '0;
        end else if (w_advance) begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_out <= w_dout;
          end
        end
      end

      assign w_out_valid = r_v2;
      assign rsp_rdata   = r_out;
    end else begin : g_noreg
      assign w_out_valid = r_v1;
      assign rsp_rdata   = w_dout;
    end
  endgenerate

  assign rsp_valid = w_out_valid;

endmodule
